// File: rtl/vga_scan_ctrl.sv
// rtl/vga_scan_ctrl.sv - VGA raster sequencer with FIFO prefill gating and underflow recovery
//   pixel_clk        pixel clock, all logic on the rising edge
//   pixel_rst        asynchronous active-high reset
//   enable_i         display enable
//   fifo_full_a_i    FIFO full flag from the write-clock domain
//   fifo_empty_i     FIFO empty flag (pixel domain)
//   fifo_read_o      FIFO read strobe, equal to blank_o
//   hs_o, vs_o       active-low horizontal / vertical sync
//   blank_o          1 = active pixel
//   x_o, y_o         active pixel column / line, valid while blank_o=1
//   frame_start_o    one-cycle pulse at the raster origin
//   resync_o         high while recovering from an underflow
//   underflow_cnt_o  saturating underflow event count
//   state_o          00 IDLE, 01 RUN, 10 RECOVER
module vga_scan_ctrl #(
  parameter int HDISP  = 800,
  parameter int VDISP  = 480,
  parameter int HFP    = 40,
  parameter int HPULSE = 48,
  parameter int HBP    = 40,
  parameter int VFP    = 13,
  parameter int VPULSE = 3,
  parameter int VBP    = 29
) (
  input  logic                     pixel_clk,
  input  logic                     pixel_rst,
  input  logic                     enable_i,
  input  logic                     fifo_full_a_i,
  input  logic                     fifo_empty_i,
  output logic                     fifo_read_o,
  output logic                     hs_o,
  output logic                     vs_o,
  output logic                     blank_o,
  output logic [$clog2(HDISP)-1:0] x_o,
  output logic [$clog2(VDISP)-1:0] y_o,
  output logic                     frame_start_o,
  output logic                     resync_o,
  output logic [7:0]               underflow_cnt_o,
  output logic [1:0]               state_o
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;
  localparam int HW     = $clog2(HTOTAL);
  localparam int VW     = $clog2(VTOTAL);
  localparam int XW     = $clog2(HDISP);
  localparam int YW     = $clog2(VDISP);

  localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
  localparam logic [HW-1:0] H_START = HW'(HFP + HPULSE + HBP);
  localparam logic [VW-1:0] V_START = VW'(VFP + VPULSE + VBP);
  localparam logic [HW-1:0] HS_BEG  = HW'(HFP);
  localparam logic [HW-1:0] HS_END  = HW'(HFP + HPULSE);
  localparam logic [VW-1:0] VS_BEG  = VW'(VFP);
  localparam logic [VW-1:0] VS_END  = VW'(VFP + VPULSE);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_RECOVER = 2'b10
  } state_e;

  state_e          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [VW-1:0]   vcnt_q, vcnt_d;
  logic            full_meta_q, full_s_q;
  logic            hs_q, hs_d;
  logic            vs_q, vs_d;
  logic            blank_q, blank_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic            frame_start_q, frame_start_d;
  logic [7:0]      ucnt_q, ucnt_d;

  logic            h_last;
  logic            frame_wrap;
  logic            underflow;
  logic            active;

  assign h_last     = (hcnt_q == H_LAST);
  assign frame_wrap = h_last && (vcnt_q == V_LAST);
  // A read strobe against an empty FIFO; only RUN ever strobes.
  assign underflow  = (state_q == ST_RUN) && blank_q && fifo_empty_i;
  assign active     = (hcnt_q >= H_START) && (vcnt_q >= V_START);

  // State register
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && full_s_q) state_d = ST_RUN;
      end
      ST_RUN: begin
        // Underflow wins over a pending disable so the event is never lost.
        if (underflow)                    state_d = ST_RECOVER;
        else if (frame_wrap && !enable_i) state_d = ST_IDLE;
      end
      ST_RECOVER: begin
        if (frame_wrap) begin
          if (!enable_i)     state_d = ST_IDLE;
          else if (full_s_q) state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State outputs
  always_comb begin
    state_o     = state_q;
    resync_o    = (state_q == ST_RECOVER);
    fifo_read_o = blank_q;
  end

  // Counter and raster next-state
  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    hs_d          = 1'b1;
    vs_d          = 1'b1;
    blank_d       = 1'b0;
    x_d           = '0;
    y_d           = '0;
    frame_start_d = 1'b0;
    ucnt_d        = ucnt_q;

    // IDLE is only entered at the frame wrap, where the counters return
    // to zero anyway, so holding on the current state is sufficient.
    if (state_q == ST_IDLE) begin
      hcnt_d = '0;
      vcnt_d = '0;
    end else if (h_last) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
    end else begin
      hcnt_d = hcnt_q + HW'(1);
    end

    if (state_q != ST_IDLE && state_d != ST_IDLE) begin
      hs_d = !((hcnt_q >= HS_BEG) && (hcnt_q < HS_END));
      vs_d = !((vcnt_q >= VS_BEG) && (vcnt_q < VS_END));
    end

    // The final pixel of a frame is presented the cycle after the wrap, so
    // it is dropped whenever the sequencer leaves RUN at that wrap; this
    // keeps the reader aligned to address 0 after a resync.
    blank_d = (state_q == ST_RUN) && (state_d == ST_RUN) && active;
    if (blank_d) begin
      x_d = XW'(hcnt_q - H_START);
      y_d = YW'(vcnt_q - V_START);
    end

    frame_start_d = ((state_q == ST_IDLE) && (state_d == ST_RUN)) ||
                    ((state_q != ST_IDLE) && frame_wrap && (state_d != ST_IDLE));

    if (underflow && (ucnt_q != 8'hFF)) ucnt_d = ucnt_q + 8'd1;
  end

  // Datapath registers
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      full_meta_q   <= 1'b0;
      full_s_q      <= 1'b0;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      blank_q       <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      ucnt_q        <= 8'd0;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      full_meta_q   <= fifo_full_a_i;
      full_s_q      <= full_meta_q;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      blank_q       <= blank_d;
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      ucnt_q        <= ucnt_d;
    end
  end

  assign hs_o            = hs_q;
  assign vs_o            = vs_q;
  assign blank_o         = blank_q;
  assign x_o             = x_q;
  assign y_o             = y_q;
  assign frame_start_o   = frame_start_q;
  assign underflow_cnt_o = ucnt_q;

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// tb/tb_vga_scan_ctrl.sv - self-checking bench for vga_scan_ctrl on a reduced raster
module tb_vga_scan_ctrl;

  localparam int HDISP = 8, VDISP = 4, HFP = 2, HPULSE = 3, HBP = 2, VFP = 1, VPULSE = 2, VBP = 2;
  localparam int HT = HDISP + HFP + HPULSE + HBP;
  localparam int VT = VDISP + VFP + VPULSE + VBP;
  localparam int FT = HT * VT;
  localparam int HSTART = HFP + HPULSE + HBP;
  localparam int VSTART = VFP + VPULSE + VBP;
  localparam int XW = $clog2(HDISP);
  localparam int YW = $clog2(VDISP);
  localparam logic [15:0] RST_VEC = 16'hC000;

  logic clk = 1'b0, rst = 1'b1, enable = 1'b0, full_a = 1'b0, empty = 1'b0;
  logic fifo_read, hs, vs, blank, frame_start, resync;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [7:0] ucnt;
  logic [1:0] state;

  int checks = 0, errors = 0;

  // Reference model: mode uses the spec codes, position is a frame cycle index.
  int m_mode, m_t, m_x, m_y, m_ucnt;
  bit m_hs, m_vs, m_blank, m_fs;
  bit [1:0] m_sync;

  vga_scan_ctrl #(.HDISP(HDISP), .VDISP(VDISP), .HFP(HFP), .HPULSE(HPULSE), .HBP(HBP),
                  .VFP(VFP), .VPULSE(VPULSE), .VBP(VBP)) dut (
    .pixel_clk(clk), .pixel_rst(rst), .enable_i(enable), .fifo_full_a_i(full_a),
    .fifo_empty_i(empty), .fifo_read_o(fifo_read), .hs_o(hs), .vs_o(vs), .blank_o(blank),
    .x_o(x), .y_o(y), .frame_start_o(frame_start), .resync_o(resync),
    .underflow_cnt_o(ucnt), .state_o(state)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_mode = 0; m_t = 0; m_x = 0; m_y = 0; m_ucnt = 0;
    m_hs = 1; m_vs = 1; m_blank = 0; m_fs = 0; m_sync = 2'b00;
  endfunction

  function automatic void model_step();
    int h, v, nm;
    bit last, uf, act;
    h = m_t % HT;
    v = m_t / HT;
    last = (m_t == FT - 1);
    uf = (m_mode == 1) && m_blank && empty;
    nm = m_mode;
    if (m_mode == 0 && enable && m_sync[1]) nm = 1;
    else if (m_mode == 1 && uf) nm = 2;
    else if (m_mode == 1 && last && !enable) nm = 0;
    else if (m_mode == 2 && last) nm = !enable ? 0 : (m_sync[1] ? 1 : 2);
    if (uf && m_ucnt < 255) m_ucnt++;
    act = (h >= HSTART) && (v >= VSTART);
    m_hs = (m_mode == 0 || nm == 0) ? 1'b1 : !(h >= HFP && h < HFP + HPULSE);
    m_vs = (m_mode == 0 || nm == 0) ? 1'b1 : !(v >= VFP && v < VFP + VPULSE);
    m_blank = (m_mode == 1) && (nm == 1) && act;
    m_x = m_blank ? h - HSTART : 0;
    m_y = m_blank ? v - VSTART : 0;
    m_fs = (m_mode == 0 && nm == 1) || (m_mode != 0 && nm != 0 && last);
    m_t = (m_mode == 0) ? 0 : (m_t + 1) % FT;
    m_sync = {m_sync[0], full_a};
    m_mode = nm;
  endfunction

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  function automatic logic [15:0] obs();
    return {hs, vs, blank, fifo_read, frame_start, resync, state, ucnt};
  endfunction

  function automatic logic [15:0] expv();
    return {m_hs, m_vs, m_blank, m_blank, m_fs, (m_mode == 2), 2'(m_mode), 8'(m_ucnt)};
  endfunction

  function automatic logic [XW+YW-1:0] xy_exp();
    return {XW'(m_x), YW'(m_y)};
  endfunction

  task automatic test_reset();
    model_reset();
    repeat (3) tick();
    checks++;
    if ({obs(), x, y} !== {RST_VEC, {(XW+YW){1'b0}}}) begin
      errors++; $display("FAIL reset_values got %h x=%0d y=%0d want %h x=0 y=0", obs(), x, y, RST_VEC);
    end
    rst = 1'b0;
    repeat (4) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL reset_release got %h want %h", obs(), expv());
      end
    end
  endtask

  task automatic test_startup();
    int fs_k = -1, bl_k = -1, hs_low = 0, vs_low = 0, rd = 0;
    enable = 1'b1; full_a = 1'b0;
    repeat ($urandom_range(20, 60)) begin
      tick();
      checks++;
      if (obs() !== expv()) begin
        errors++; $display("FAIL prefill_lockstep got %h want %h", obs(), expv());
      end
    end
    checks++;
    if ({hs, vs, blank, state} !== 5'b11000) begin
      errors++; $display("FAIL prefill_idle got hs=%b vs=%b blank=%b state=%b want 1 1 0 00", hs, vs, blank, state);
    end
    full_a = 1'b1;
    for (int k = 1; k <= 4 + 2 * FT; k++) begin
      tick();
      checks++;
      if (obs() !== expv() || (m_blank && {x, y} !== xy_exp())) begin
        errors++; $display("FAIL startup_lockstep k=%0d got %h x=%0d y=%0d want %h x=%0d y=%0d", k, obs(), x, y, expv(), m_x, m_y);
      end
      if (frame_start && fs_k < 0) fs_k = k;
      if (blank && bl_k < 0) bl_k = k;
      if (k >= 4 && k < 4 + 2 * FT) begin
        hs_low += int'(!hs); vs_low += int'(!vs); rd += int'(fifo_read);
      end
    end
    checks++;
    if (fs_k !== 3) begin errors++; $display("FAIL startup_fs_latency got %0d want 3", fs_k); end
    checks++;
    if (bl_k !== 3 + VSTART * HT + HSTART + 1) begin
      errors++; $display("FAIL startup_first_blank got %0d want %0d", bl_k, 3 + VSTART * HT + HSTART + 1);
    end
    checks++;
    if (hs_low !== 2 * VT * HPULSE) begin errors++; $display("FAIL geom_hs_low got %0d want %0d", hs_low, 2 * VT * HPULSE); end
    checks++;
    if (vs_low !== 2 * VPULSE * HT) begin errors++; $display("FAIL geom_vs_low got %0d want %0d", vs_low, 2 * VPULSE * HT); end
    checks++;
    if (rd !== 2 * HDISP * VDISP) begin errors++; $display("FAIL geom_reads got %0d want %0d", rd, 2 * HDISP * VDISP); end
  endtask

  task automatic test_underflow();
    int k, u0, tgt;
    tgt = (VSTART + $urandom_range(0, VDISP - 2)) * HT + HSTART + 1 + $urandom_range(0, HDISP - 2);
    for (k = 0; k < 2 * FT && !(m_mode == 1 && m_t == tgt); k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL uf_wait got %h want %h", obs(), expv()); end
    end
    checks++;
    if (blank !== 1'b1 || state !== 2'b01) begin
      errors++; $display("FAIL uf_reach got blank=%b state=%b want 1 01", blank, state);
    end
    u0 = m_ucnt;
    empty = 1'b1; tick(); empty = 1'b0;
    checks++;
    if ({ucnt, blank, fifo_read, resync, state} !== {8'(u0 + 1), 5'b00110}) begin
      errors++; $display("FAIL uf_edge got cnt=%0d blank=%b rd=%b resync=%b state=%b want cnt=%0d 0 0 1 10",
                         ucnt, blank, fifo_read, resync, state, u0 + 1);
    end
    for (k = 0; k < 2 * FT && state !== 2'b01; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL uf_recover got %h want %h", obs(), expv()); end
    end
    checks++;
    if (k !== FT - 1 - tgt || frame_start !== 1'b1 || resync !== 1'b0) begin
      errors++; $display("FAIL uf_resume got k=%0d fs=%b resync=%b want k=%0d fs=1 resync=0", k, frame_start, resync, FT - 1 - tgt);
    end
    for (k = 0; k < 2 * FT && !(m_mode == 1 && m_t == FT - 1); k++) tick();
    empty = 1'b1; tick(); empty = 1'b0;
    checks++;
    if (state !== 2'b10 || ucnt !== 8'(u0 + 2)) begin
      errors++; $display("FAIL uf_last_enter got state=%b cnt=%0d want 10 cnt=%0d", state, ucnt, u0 + 2);
    end
    for (k = 0; k < 2 * FT && state !== 2'b01; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL uf_last_lockstep got %h want %h", obs(), expv()); end
    end
    checks++;
    if (k !== FT) begin errors++; $display("FAIL uf_last_len got %0d want %0d", k, FT); end
  endtask

  task automatic test_extended_recovery();
    int k;
    for (k = 0; k < 2 * FT && !(m_mode == 1 && m_blank && m_t >= FT / 2 && m_t < FT - HT); k++) tick();
    empty = 1'b1; full_a = 1'b0; tick(); empty = 1'b0;
    for (k = 0; k < FT + FT / 2; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL ext_lockstep got %h want %h", obs(), expv()); end
    end
    checks++;
    if (state !== 2'b10 || resync !== 1'b1) begin
      errors++; $display("FAIL ext_hold got state=%b resync=%b want 10 1", state, resync);
    end
    full_a = 1'b1;
    for (k = 0; k < 2 * FT && state !== 2'b01; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL ext_resume_lockstep got %h want %h", obs(), expv()); end
    end
    checks++;
    if (state !== 2'b01 || frame_start !== 1'b1) begin
      errors++; $display("FAIL ext_resume got state=%b fs=%b want 01 1", state, frame_start);
    end
  endtask

  task automatic test_saturation();
    for (int f = 0; f < 300 * FT; f++) begin
      empty = ($urandom_range(0, 7) == 0);
      tick();
      checks++;
      if (obs() !== expv() || (m_blank && {x, y} !== xy_exp())) begin
        errors++; $display("FAIL sat_lockstep got %h want %h", obs(), expv());
      end
    end
    empty = 1'b0;
    checks++;
    if (ucnt !== 8'hFF) begin errors++; $display("FAIL sat_value got %0d want 255", ucnt); end
  endtask

  task automatic test_disable();
    int k, t0, tgt;
    tgt = $urandom_range(FT / 3, 2 * FT / 3);
    for (k = 0; k < 3 * FT && !(m_mode == 1 && m_t == tgt); k++) tick();
    t0 = m_t;
    enable = 1'b0;
    for (k = 0; k < 2 * FT && state !== 2'b00; k++) begin
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL dis_lockstep got %h want %h", obs(), expv()); end
    end
    checks++;
    if (k !== FT - t0) begin errors++; $display("FAIL dis_len got %0d want %0d", k, FT - t0); end
    repeat (5) tick();
    checks++;
    if ({hs, vs, blank, fifo_read, state} !== 6'b110000) begin
      errors++; $display("FAIL dis_idle got hs=%b vs=%b blank=%b rd=%b state=%b want 1 1 0 0 00", hs, vs, blank, fifo_read, state);
    end
  endtask

  task automatic test_reset_midline();
    int k;
    enable = 1'b1; full_a = 1'b1;
    for (k = 0; k < 3 * FT && !(m_mode == 1 && m_t == VSTART * HT + HSTART + 3); k++) tick();
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({obs(), x, y} !== {RST_VEC, {(XW+YW){1'b0}}}) begin
      errors++; $display("FAIL rst_async got %h x=%0d y=%0d want %h x=0 y=0", obs(), x, y, RST_VEC);
    end
    model_reset();
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) begin
      tick();
      checks++;
      if (obs() !== expv()) begin errors++; $display("FAIL post_rst got %h want %h", obs(), expv()); end
    end
  endtask

  initial begin
    test_reset();
    test_startup();
    test_underflow();
    test_extended_recovery();
    test_saturation();
    test_disable();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_scan_ctrl.md
# vga_scan_ctrl

Pixel-domain sequencer for the VGA display path. It generates the HS/VS/BLANK raster timing and gates reads from the pixel FIFO. It holds the raster off until the FIFO has been prefilled, detects FIFO underflow, and re-synchronises the display at a frame boundary. It sits between the async pixel FIFO read port and the `video_if` master signals, and exports a resync request for the Wishbone-side reader.

## Interface
- HDISP, 800, active pixels per line
- VDISP, 480, active lines per frame
- HFP / HPULSE / HBP, 40 / 48 / 40, horizontal front porch / sync / back porch (pixels)
- VFP / VPULSE / VBP, 13 / 3 / 29, vertical front porch / sync / back porch (lines)
- pixel_clk  in  1  pixel clock; all logic on rising edge
- pixel_rst  in  1  reset, asynchronous, active-high
- enable  in  1  display enable (pixel domain)
- fifo_full_a  in  1  FIFO wfull, write-clock domain; 2-flop synchronised internally to full_s
- fifo_empty  in  1  FIFO rempty (pixel domain)
- fifo_read  out  1  FIFO read strobe
- hs, vs  out  1  sync outputs, active-low
- blank  out  1  1 = active pixel (video_if BLANK polarity)
- x  out  $clog2(HDISP)  active column, valid when blank=1
- y  out  $clog2(VDISP)  active line, valid when blank=1
- frame_start  out  1  one-cycle pulse at raster origin
- resync  out  1  level; high while recovering; reader restarts address 0 on its rising edge after synchronisation
- underflow_cnt  out  8  saturating underflow event count
- state  out  2  00 IDLE, 01 RUN, 10 RECOVER

## Operation
- HTOTAL = HDISP+HFP+HPULSE+HBP; VTOTAL = VDISP+VFP+VPULSE+VBP. Counters: hcnt in 0..HTOTAL-1, vcnt in 0..VTOTAL-1. vcnt increments when hcnt wraps; both wrap to 0.
- HSTART = HFP+HPULSE+HBP; VSTART = VFP+VPULSE+VBP.
- Raster (registered from counters): hs=0 iff HFP≤hcnt<HFP+HPULSE. vs=0 iff VFP≤vcnt<VFP+VPULSE. active iff hcnt≥HSTART and vcnt≥VSTART. x=hcnt−HSTART, y=vcnt−VSTART.
- fifo_read = blank (combinational from the blank register).
- IDLE: counters held at 0; hs=vs=1, blank=0, resync=0. Go to RUN when enable=1 and full_s=1.
- RUN: counters free-run; blank follows the active window.
  - Underflow = fifo_read & fifo_empty in the same cycle. On underflow: underflow_cnt+1 (saturates at 255), then RECOVER on the next cycle.
  - enable=0: finish the current frame, then enter IDLE at the frame wrap (hcnt=HTOTAL-1, vcnt=VTOTAL-1).
- RECOVER: counters and hs/vs keep running; blank forced 0 (no reads); resync=1.
  - Go to RUN at the frame wrap if full_s=1.
  - If full_s=0 at the wrap, stay in RECOVER through the next frame.
  - enable=0 during RECOVER goes to IDLE at the frame wrap.
- frame_start: pulses for one cycle when the counters wrap to (0,0) in RUN or RECOVER, and on the IDLE→RUN transition.

## Timing
- Reset values: state=IDLE, counters 0, hs=vs=1, blank=0, fifo_read=0, x=y=0, frame_start=0, resync=0, underflow_cnt=0, full sync flops 0.
- full_s lags fifo_full_a by 2 pixel_clk cycles. IDLE→RUN happens 1 cycle after full_s=1.
- Raster outputs lag the counters by 1 cycle. The first blank=1 appears at hcnt=HSTART+1, vcnt=VSTART, counting cycles from when the counter reached that value.
- Underflow at cycle n: blank=0 and fifo_read=0 at n+1. The same cycle a one-cycle read hazard pulse is not re-counted. At most one count per RECOVER entry.
- Underflow on the last cycle of a frame still enters RECOVER. The wrap check applies from the next frame only.
- pixel_rst mid-frame: immediate asynchronous return to reset values. No partial-frame completion.

## Test plan
- Startup: reset, enable=1, fifo_full_a=0 for 100 cycles, then 1 → hs=vs=1 and blank=0 until 3 cycles after the rise. frame_start then pulses once, and the first blank=1 follows HSTART+1 cycles into line VSTART.
- Raster geometry with defaults over 2 frames → hs low 48 cycles per 928-cycle line; vs low 3 lines per 525; 800 blank=1 cycles per active line; 384000 fifo_read per frame.
- Underflow: force fifo_empty=1 at a mid-frame active pixel → underflow_cnt=1, blank=0 the next cycle, and resync=1. Keep full_s=1 → RUN resumes at the next frame origin and resync drops.
- Extended recovery: underflow with fifo_full_a=0 across the next wrap → stays in RECOVER a further full frame. 256+ underflows → underflow_cnt saturates at 255.
- Disable: enable=0 mid-frame → frame completes, then IDLE, hs=vs=1. Separately, assert pixel_rst mid-line → all outputs at reset values within the same cycle.
